ternary_neuron_seq: RTL and testbench
=====================================

// Module: ternary_neuron_seq
// PURPOSE
//  Parametrised sequential ternary neuron. Accepts an N-input vector of unsigned multi-bit
//  activations and a packed ternary weight vector over a valid/ready handshake.
//  Accumulates one weighted term per cycle onto a signed bias, then applies a selectable
//  activation and returns a saturated result over a second valid/ready handshake.
//  Serves as the building block for multi-neuron layers behind the project I/O wrapper.
// PARAMETERS
//  N_INPUTS  8  number of inputs/weights per neuron (>=2)
//  IN_W      4  width of each unsigned input activation
//  BIAS_W    8  width of signed bias
//  OUT_W     8  width of signed output (saturating)
//  ACC_W     derived: max(IN_W+$clog2(N_INPUTS+1), BIAS_W)+1, signed accumulator; never overflows
// PORTS
//  clk        in   1            rising-edge clock
//  reset_n    in   1            asynchronous, active-low reset
//  in_valid   in   1            request valid
//  in_ready   out  1            block can accept (high only in IDLE)
//  in_data    in   N_INPUTS*IN_W  input i = in_data[i*IN_W +: IN_W], unsigned
//  weights    in   2*N_INPUTS   weight i = weights[2*i +: 2]; 01=+1, 11=-1, 00/10=0
//  bias       in   BIAS_W       signed, accumulator start value
//  mode       in   2            activation: 00 raw, 01 ReLU, 10 step, 11 sign
//  threshold  in   OUT_W        signed; used by step/sign modes
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts result
//  out_data   out  OUT_W        signed result
//  busy       out  1            high in ACCUM or DONE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, index 0, acc 0; in_ready=1 after release;
//    out_valid=0, out_data=0, busy=0.
//  - FSM IDLE -> ACCUM on in_valid&&in_ready: latch in_data, weights, mode, threshold;
//    acc <= sign-extended bias; idx <= 0. Later changes to these inputs have no effect.
//  - ACCUM: each cycle acc += term(idx): +in, -in or 0 per weight code; idx++.
//    After the term at idx=N_INPUTS-1, go to DONE, registering out_data.
//  - Latency: out_valid rises exactly N_INPUTS+1 cycles after the accept edge.
//  - DONE: out_valid=1, out_data stable until out_ready=1; then -> IDLE and out_valid=0
//    on the next edge. in_ready stays 0 in DONE; no same-cycle re-accept.
//  - Activation on the final sum s (ACC_W), then saturated to OUT_W:
//    raw: sat(s); ReLU: s<0 ? 0 : sat(s); step: s>threshold ? 1 : 0;
//    sign: s>threshold ? +1 : (s< -threshold ? -1 : 0). A negative threshold in sign mode
//    is treated as 0.
//  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; no wrap-around.
//  - out_data keeps its value after a handshake until the next result (reset clears it to 0).
//  - reset_n low in ACCUM or DONE: the operation is aborted, nothing is emitted and all
//    outputs take their reset values.
//  - in_valid held high while busy: ignored; the request is accepted on the first IDLE cycle.
// STRUCTURE
//  - ternary_pkg: weight codes (W_ZERO=2'b00, W_POS=2'b01, W_NEG=2'b11), mode encodings,
//    state encoding, and functions acc_width() and sat_to().
//  - Sub-module ternary_term (combinational): {code, in} -> signed ACC_W term; reusable by
//    the future parallel-lane variant.
//  - Top: FSM, idx counter ($clog2(N_INPUTS) bits), operand and weight registers,
//    accumulator, activation/saturation stage.
// TESTING (N_INPUTS=8, IN_W=4, BIAS_W=8, OUT_W=8)
//  1. All weights 01, all inputs 15, bias 0, raw -> out_data=120, out_valid exactly 9 cycles
//     after accept.
//  2. All weights 11, inputs 15, bias 0: raw -> -120; ReLU -> 0.
//  3. All weights 01, inputs 15, bias 127, raw -> 127 (saturated). Weights 11, bias -128
//     -> -128.
//  4. Weight codes alternating 10/01, inputs 0..7, bias 0, raw -> 1+3+5+7=16 (10 counts as 0).
//     Step with threshold 16 -> 0; threshold 15 -> 1. Sign with threshold 20 -> 0.
//  5. Backpressure: hold out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0;
//     toggle in_data/weights mid-ACCUM -> result unchanged.
//  6. Pulse reset_n low at idx=4 -> out_valid=0, in_ready=1 after release; the next request
//     gives a correct fresh result.

Source files
------------

// File: rtl/ternary_neuron_seq_pkg.sv
// ternary_pkg: weight codes, mode/state encodings and sizing/saturation helpers
// shared by the ternary neuron and its term datapath.
package ternary_pkg;
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS = 2'b01;
    localparam logic [1:0] W_NEG = 2'b11;

    typedef enum logic [1:0] {
        MODE_RAW  = 2'b00,
        MODE_RELU = 2'b01,
        MODE_STEP = 2'b10,
        MODE_SIGN = 2'b11
    } mode_e;

    // S_ACT holds the final sum for one cycle while the activation is registered.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ACT,
        S_DONE
    } state_e;

    function automatic int acc_width(input int n, input int in_w, input int bias_w);
        int sum_w;
        sum_w = in_w + $clog2(n + 1);
        return (sum_w > bias_w ? sum_w : bias_w) + 1;
    endfunction

    function automatic logic signed [63:0] sat_to(input logic signed [63:0] s, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
endpackage

// File: rtl/ternary_neuron_seq_if.sv
// ternary_neuron_seq_if: request/response handshake bundle of the ternary neuron.
interface ternary_neuron_seq_if #(
    parameter int N_INPUTS = 8,
    parameter int IN_W     = 4,
    parameter int BIAS_W   = 8,
    parameter int OUT_W    = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N_INPUTS*IN_W-1:0]    in_data;
    logic [2*N_INPUTS-1:0]       weights;
    logic signed [BIAS_W-1:0]    bias;
    logic [1:0]                  mode;
    logic signed [OUT_W-1:0]     threshold;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_W-1:0]     out_data;
    logic                        busy;

    modport master (
        output in_valid, in_data, weights, bias, mode, threshold, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, weights, bias, mode, threshold, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/ternary_neuron_seq_term.sv
// ternary_term: maps a ternary weight code and an unsigned activation to a signed term
// (+in, -in or 0); codes 00 and 10 both contribute nothing.
module ternary_term
    import ternary_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int ACC_W = 9
) (
    input  logic [1:0]              code_i,
    input  logic [IN_W-1:0]         in_i,
    output logic signed [ACC_W-1:0] term_o
);
    logic signed [ACC_W-1:0] mag;

    assign mag    = signed'(ACC_W'(in_i));
    assign term_o = code_i == W_POS ? mag : (code_i == W_NEG ? -mag : '0);
endmodule

// File: rtl/ternary_neuron_seq.sv
// ternary_neuron_seq: sequential ternary neuron; adds one weighted input per cycle onto
// the bias, then applies the latched activation mode and saturates to OUT_W.
module ternary_neuron_seq
    import ternary_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int IN_W     = 4,
    parameter int BIAS_W   = 8,
    parameter int OUT_W    = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    ternary_neuron_seq_if.slave bus
);
    localparam int ACC_W = acc_width(N_INPUTS, IN_W, BIAS_W);
    localparam int IDX_W = $clog2(N_INPUTS);

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  term_w;
    logic [N_INPUTS*IN_W-1:0] data_q;
    logic [2*N_INPUTS-1:0]    w_q;
    mode_e                    mode_q;
    logic signed [OUT_W-1:0]  thr_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic signed [OUT_W-1:0]  act_d;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;

    // Comparisons run in 64 bits so the threshold and the sum need no common width.
    function automatic logic signed [OUT_W-1:0] activate(
        input logic signed [ACC_W-1:0] s,
        input mode_e                   m,
        input logic signed [OUT_W-1:0] t
    );
        logic signed [63:0] sw;
        logic signed [63:0] tw;
        logic signed [63:0] te;
        sw = 64'(s);
        tw = 64'(t);
        te = tw < 64'sd0 ? 64'sd0 : tw;
        return OUT_W'(m == MODE_RAW  ? sat_to(sw, OUT_W) :
                      m == MODE_RELU ? (sw < 64'sd0 ? 64'sd0 : sat_to(sw, OUT_W)) :
                      m == MODE_STEP ? (sw > tw ? 64'sd1 : 64'sd0) :
                                       (sw > te ? 64'sd1 : (sw < -te ? -64'sd1 : 64'sd0)));
    endfunction

    ternary_term #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_term (
        .code_i (w_q[2*int'(idx_q) +: 2]),
        .in_i   (data_q[int'(idx_q)*IN_W +: IN_W]),
        .term_o (term_w)
    );

    assign act_d = activate(acc_q, mode_q, thr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            w_q         <= '0;
            mode_q      <= MODE_RAW;
            thr_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    data_q     <= bus.in_data;
                    w_q        <= bus.weights;
                    mode_q     <= mode_e'(bus.mode);
                    thr_q      <= bus.threshold;
                    acc_q      <= ACC_W'(bus.bias);
                    idx_q      <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_ACCUM;
                end
                S_ACCUM: begin
                    acc_q <= acc_q + term_w;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(N_INPUTS - 1)) state_q <= S_ACT;
                end
                S_ACT: begin
                    out_data_q  <= act_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ternary_neuron_seq.sv
// tb_ternary_neuron_seq: directed vectors with hand-computed results for the
// sequential ternary neuron (N_INPUTS=8, IN_W=4, BIAS_W=8, OUT_W=8).
module tb_ternary_neuron_seq;
    import ternary_pkg::*;

    localparam int N  = 8;
    localparam int IW = 4;
    localparam int BW = 8;
    localparam int OW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nv = 0;
    int   nf = 0;

    ternary_neuron_seq_if #(.N_INPUTS(N), .IN_W(IW), .BIAS_W(BW), .OUT_W(OW)) bus ();

    ternary_neuron_seq #(.N_INPUTS(N), .IN_W(IW), .BIAS_W(BW), .OUT_W(OW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nv++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [15:0] w, input logic signed [7:0] b,
                        input logic [1:0] m, input logic signed [7:0] t, input bit hold);
        int k = 0;
        @(negedge clk);
        bus.in_data   = d;
        bus.weights   = w;
        bus.bias      = b;
        bus.mode      = m;
        bus.threshold = t;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input int exp, input int start);
        int cyc = start;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_data"}, bus.out_data, exp);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_valid", bus.out_valid, 0);
        chk("release_ready", bus.in_ready, 1);
    endtask

    task automatic run(input string tag, input logic [31:0] d, input logic [15:0] w,
                       input logic signed [7:0] b, input logic [1:0] m, input logic signed [7:0] t,
                       input int exp);
        send(d, w, b, m, t, 1'b0);
        wait_result(tag, 9, exp, 0);
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.weights   = '0;
        bus.bias      = '0;
        bus.mode      = '0;
        bus.threshold = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        reset_n = 1'b1;

        run("all_pos_raw", 32'hFFFF_FFFF, 16'h5555, 8'sd0, MODE_RAW, 8'sd0, 120);
        chk("hold_after_handshake", bus.out_data, 120);
        run("all_neg_raw", 32'hFFFF_FFFF, 16'hFFFF, 8'sd0, MODE_RAW, 8'sd0, -120);
        run("all_neg_relu", 32'hFFFF_FFFF, 16'hFFFF, 8'sd0, MODE_RELU, 8'sd0, 0);
        run("sat_pos", 32'hFFFF_FFFF, 16'h5555, 8'sd127, MODE_RAW, 8'sd0, 127);
        run("sat_neg", 32'hFFFF_FFFF, 16'hFFFF, -8'sd128, MODE_RAW, 8'sd0, -128);
        run("alt_raw", 32'h7654_3210, 16'h6666, 8'sd0, MODE_RAW, 8'sd0, 16);
        run("alt_step16", 32'h7654_3210, 16'h6666, 8'sd0, MODE_STEP, 8'sd16, 0);
        run("alt_step15", 32'h7654_3210, 16'h6666, 8'sd0, MODE_STEP, 8'sd15, 1);
        run("alt_sign20", 32'h7654_3210, 16'h6666, 8'sd0, MODE_SIGN, 8'sd20, 0);
        run("alt_sign10", 32'h7654_3210, 16'h6666, 8'sd0, MODE_SIGN, 8'sd10, 1);
        run("zero_w_relu", 32'hFFFF_FFFF, 16'h0000, 8'sd5, MODE_RELU, 8'sd0, 5);
        run("sign_negthr_neg", 32'hFFFF_FFFF, 16'hFFFF, 8'sd0, MODE_SIGN, -8'sd5, -1);
        run("sign_negthr_zero", 32'hFFFF_FFFF, 16'hAAAA, 8'sd0, MODE_SIGN, -8'sd5, 0);

        // Backpressure with inputs churning mid-accumulation and in_valid held high.
        send(32'h7654_3210, 16'h6666, 8'sd0, MODE_RAW, 8'sd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.in_data   = $urandom;
            bus.weights   = 16'($urandom);
            bus.bias      = 8'($urandom);
            bus.mode      = 2'($urandom);
            bus.threshold = 8'($urandom);
            @(negedge clk);
        end
        chk("bp_busy", bus.busy, 1);
        bus.in_data   = 32'hFFFF_FFFF;
        bus.weights   = 16'h5555;
        bus.bias      = 8'sd0;
        bus.mode      = MODE_RAW;
        bus.threshold = 8'sd0;
        wait_result("bp", 9, 16, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 16);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        consume();
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("reaccept_busy", bus.busy, 1);
        wait_result("reaccept", 9, 120, 0);
        consume();

        // Abort at idx=4.
        send(32'hFFFF_FFFF, 16'hFFFF, 8'sd0, MODE_RAW, 8'sd0, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_data", bus.out_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_abort_valid", bus.out_valid, 0);
        run("after_abort", 32'h7654_3210, 16'h6666, 8'sd0, MODE_RAW, 8'sd0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end
endmodule
